// File: rtl/muldiv_pkg.sv
// Shared types and ALU opcode constants for the sequential MUL/DIVU/REMU unit.
package muldiv_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd5;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIVU = 2'b01,
        MD_REMU = 2'b10,
        MD_RSVD = 2'b11
    } md_op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL_STEP,
        DIV_CMP,
        DIV_SUB,
        DONE
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Combinational integer ALU; SLT is an unsigned compare. Flags assume WIDTH=32.
module alu_muldiv_seq_alu
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_cntrl,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             over_flow
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum       = '0;
        result    = '0;
        carry     = 1'b0;
        over_flow = 1'b0;
        case (alu_cntrl)
            ALU_ADD: begin
                sum       = {1'b0, a} + {1'b0, b};
                result    = sum[WIDTH-1:0];
                carry     = sum[WIDTH];
                over_flow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                sum       = {1'b0, a} - {1'b0, b};
                result    = sum[WIDTH-1:0];
                carry     = sum[WIDTH];
                over_flow = (a[31] != b[31]) && (sum[31] != a[31]);
            end
            3'd2:    result = a & b;
            3'd3:    result = a | b;
            3'd4:    result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
            3'd6:    result = a << b[4:0];
            default: result = a >> b[4:0];
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[31];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL (low word) / DIVU / REMU sequencer driving one shared ALU.
module alu_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result
);

    state_t           state, state_nxt;
    md_op_t           op;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] acc, mc, mp;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             ge;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             alu_unused_carry, alu_unused_zero, alu_unused_neg, alu_unused_ovf;

    logic [WIDTH-1:0] acc_nxt, rem_nxt, quo_nxt, rsp_nxt, r1;
    logic             accept, load_rsp, ov, lt;

    assign req_ready = (state == IDLE) && !flush && !rst;
    assign rsp_valid = (state == DONE);
    assign accept    = req_valid && req_ready;
    // rem:quo acts as one 64-bit shift register; ov is the bit shifted out of rem
    assign r1        = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign ov        = rem[WIDTH-1];
    assign lt        = alu_y[0];

    alu_muldiv_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .alu_cntrl (alu_op),
        .result    (alu_y),
        .carry     (alu_unused_carry),
        .zero      (alu_unused_zero),
        .negative  (alu_unused_neg),
        .over_flow (alu_unused_ovf)
    );

    always_comb begin
        state_nxt = state;
        alu_op    = ALU_ADD;
        alu_a     = acc;
        alu_b     = mc;
        acc_nxt   = acc;
        rem_nxt   = rem;
        quo_nxt   = quo;
        rsp_nxt   = '0;
        load_rsp  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (md_op_t'(req_op))
                        MD_MUL:           state_nxt = MUL_STEP;
                        MD_DIVU, MD_REMU: state_nxt = DIV_CMP;
                        MD_RSVD: begin
                            state_nxt = DONE;
                            load_rsp  = 1'b1;
                        end
                        default:          state_nxt = IDLE;
                    endcase
                end
            end
            MUL_STEP: begin
                if (mp[0]) acc_nxt = alu_y;
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                    load_rsp  = 1'b1;
                    rsp_nxt   = acc_nxt;
                end
            end
            DIV_CMP: begin
                alu_op    = ALU_SLT;
                alu_a     = r1;
                alu_b     = dvs;
                rem_nxt   = r1;
                quo_nxt   = {quo[WIDTH-2:0], 1'b0};
                state_nxt = DIV_SUB;
            end
            DIV_SUB: begin
                alu_op  = ALU_SUB;
                alu_a   = rem;
                alu_b   = dvs;
                if (ge) rem_nxt = alu_y;
                quo_nxt = {quo[WIDTH-1:1], ge};
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                    load_rsp  = 1'b1;
                    rsp_nxt   = (op == MD_REMU) ? rem_nxt : quo_nxt;
                end else begin
                    state_nxt = DIV_CMP;
                end
            end
            DONE: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            load_rsp  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= MD_MUL;
            cnt        <= '0;
            acc        <= '0;
            mc         <= '0;
            mp         <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            ge         <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                op  <= md_op_t'(req_op);
                cnt <= '0;
                acc <= '0;
                mc  <= req_a;
                mp  <= req_b;
                rem <= '0;
                quo <= req_a;
                dvs <= req_b;
            end else begin
                acc <= acc_nxt;
                rem <= rem_nxt;
                quo <= quo_nxt;
                if (state == MUL_STEP) begin
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt + 5'd1;
                end
                if (state == DIV_CMP) ge <= ov || !lt;
                if (state == DIV_SUB) cnt <= cnt + 5'd1;
            end
            if (load_rsp) rsp_result <= rsp_nxt;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: results, latency, backpressure, flush and reset.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    int checks;
    int failures;

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        do_req(op, a, b);
        wait_rsp(lat);
        check_eq({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_res"}, rsp_result, exp);
        if (exp_lat > 0) check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        check_eq({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_result", rsp_result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33);
        run_op("mul_ffff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 65);
        run_op("remu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 65);
        run_op("divu_ov", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 0);
        run_op("remu_ov", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0);
        run_op("divu_zero", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_zero", 2'b10, 32'h1234, 32'd0, 32'h1234, 0);
        run_op("rsvd", 2'b11, 32'd55, 32'd66, 32'd0, 1);

        // backpressure in DONE
        rsp_ready = 1'b0;
        do_req(2'b00, 32'h0001_0000, 32'h0000_0010);
        wait_rsp(lat);
        check_eq("bp_res", rsp_result, 32'h0010_0000);
        held = rsp_result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_vld_hold", 32'(rsp_valid), 32'd1);
            check_eq("bp_res_hold", rsp_result, held);
            check_eq("bp_ready_low", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release", 32'(rsp_valid), 32'd0);

        // flush around DIV step 20
        do_req(2'b01, 32'd1000, 32'd3);
        repeat (40) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check_eq("flush_ready_low", 32'(req_ready), 32'd0);
        check_eq("flush_vld", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_idle", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check_eq("flush_no_rsp", 32'(seen), 32'd0);
        run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15, 33);

        // asynchronous reset mid-MUL
        do_req(2'b00, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_result", rsp_result, 32'd0);
        check_eq("arst_vld", 32'(rsp_valid), 32'd0);
        check_eq("arst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("arst_release_ready", 32'(req_ready), 32'd1);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that performs unsigned MUL (low word), DIVU and REMU by driving a single internal ALU instance one operation per cycle. It sits beside the EX stage: the pipeline hands it operands over a valid/ready request channel, stalls while it iterates, and collects the result over a valid/ready response channel. Fixed-latency algorithms (shift-add, restoring division) keep it simple to stall around and to verify.

## Interface
- WIDTH, 32, datapath width; only 32 is supported because the ALU hardcodes bit 31.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush; aborts any operation in progress.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state==IDLE) && !flush && !rst.
- req_op  in  2  00 MUL, 01 DIVU, 10 REMU, 11 reserved.
- req_a  in  WIDTH  multiplicand or dividend.
- req_b  in  WIDTH  multiplier or divisor.
- rsp_valid  out  1  result available; held until taken.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  WIDTH  registered result.

## Operation
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE. 5-bit step counter cnt.
- IDLE: on req_valid && req_ready, latch operands and op, cnt=0. MUL goes to MUL_STEP; DIVU/REMU go to DIV_CMP; op 11 goes straight to DONE with rsp_result=0.
- MUL (shift-add): registers acc=0, mc=req_a, mp=req_b. Each MUL_STEP cycle: ALU op ADD (3'd0), a=acc, b=mc. If mp[0], acc takes the ALU result. Then mc<<=1 and mp>>=1, both done locally. After cnt==31, go to DONE; rsp_result=acc.
- DIV (restoring): registers rem=0, quo=req_a (dividend shifts out MSB-first into rem, quotient bits shift in at LSB), dvs=req_b.
- DIV_CMP: form r1={rem[30:0],quo[31]} and capture ov=rem[31] (33rd bit). ALU op SLT (3'd5, unsigned a<b), a=r1, b=dvs, giving lt=result[0]. Store r1 into rem, shift quo left by one, and set ge = ov || !lt.
- DIV_SUB: if ge, rem takes ALU SUB (3'd1) of a=rem, b=dvs. Unsigned 32-bit wrap is correct when ov=1. Set quo[0]=ge. If cnt==31 go to DONE, else cnt++ and return to DIV_CMP.
- DONE: DIVU returns quo; REMU returns rem.
- Only the ALU result output is used. The carry, zero, negative and over_flow flags are ignored.
- Divide by zero is not special-cased. The algorithm yields quotient 0xFFFFFFFF and remainder = dividend, which matches the RISC-V definition.
- ALU op encodings used: ADD 0, SUB 1, SLT 5.

## Timing
- Reset: state IDLE, cnt=0, all data registers 0, rsp_valid=0, rsp_result=0. req_ready=0 while rst is high and 1 after release.
- Latency is counted from the accepting edge to the first cycle rsp_valid is high.
  - MUL: 33 cycles (32 steps plus DONE entry).
  - DIVU/REMU: 65 cycles (32×2 steps plus DONE entry).
  - Reserved op: 1 cycle.
- DONE: rsp_valid=1 and rsp_result is stable. A rsp_valid && rsp_ready edge returns the block to IDLE, and rsp_valid drops the next cycle.
- A new request is accepted no earlier than the cycle after return to IDLE. There are no back-to-back operations.
- Backpressure: DONE holds indefinitely while rsp_ready=0.
- flush has the highest priority below rst. From any state it forces IDLE on the next edge and clears rsp_valid, and the result is discarded. While flush is high, req_ready=0, so a simultaneous req_valid is not accepted. If flush and rsp_ready arrive together in DONE, the result counts as discarded.
- rst mid-operation returns the block to IDLE immediately (asynchronously), with all registers cleared.
- Operands are sampled only at acceptance. Later changes on req_a and req_b are ignored.

## Structure
- Package muldiv_pkg holds:
  - ALU op localparams: ALU_ADD=3'd0, ALU_SUB=3'd1, ALU_SLT=3'd5.
  - the op enum: MD_MUL, MD_DIVU, MD_REMU, MD_RSVD.
  - the state enum.
- One sub-module: the existing ALU, instantiated as u_alu with WIDTH=32. Its inputs a, b and alu_cntrl are muxed combinationally from the state. Only its result output is connected.

## Test plan
- MUL 7×6, rsp_ready=1 → rsp_valid exactly 33 cycles after accept, result 42. Also 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- DIVU 100/7 → 14 at 65 cycles; REMU 100/7 → 2.
- DIVU 0xFFFFFFFF/0x80000001 → 1; REMU of the same operands → 0x7FFFFFFE. This case exercises the ov path.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
- Backpressure and flush:
  - Hold rsp_ready=0 for 10 cycles in DONE → rsp_valid and rsp_result stay stable and req_ready stays 0.
  - Assert flush at DIV step 20 → IDLE next cycle, rsp_valid never asserts.
  - A new MUL 3×5 issued afterwards → 15.
- Assert rst mid-MUL → all outputs zero immediately. After release, req_ready=1 and a fresh DIVU 9/3 → 3.
